// File: rtl/present_key_scheduler.sv
// PRESENT-80 key scheduler.
//
// Owns the 80-bit PRESENT key register and advances it through one shared
// combinational key-update stage, one step per accepted round key. Round keys
// K1..K{NUM_RK} go to the round datapath over a valid/ready stream.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   key_valid_i    master key offered; accepted when key_ready_o is high
//   key_i          80-bit master key, sampled on the key handshake
//   key_ready_o    high in IDLE unless abort_i is asserted
//   abort_i        synchronous abort; drops the schedule, wins over handshakes
//   rk_valid_o     round key on rk_o is valid (state is RUN)
//   rk_ready_i     consumer accepts the round key
//   rk_o           current round key, key_reg[79:16]
//   rk_idx_o       index of the round key on rk_o, 1..NUM_RK
//   last_o         high with rk_valid_o on the final round key
//   done_o         one-cycle pulse after the final round key is accepted
//   busy_o         high in RUN

// One PRESENT-80 key-register update step (rotate, S-box, counter XOR).
module key_update (
   input  logic [79:0] key_in,
   input  logic [4:0]  round_cnt,
   output logic [79:0] key_next_c
);

   localparam int unsigned KEY_W = 80;

   // PRESENT 4-bit S-box
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   logic [KEY_W-1:0] rot_c;

   // Rotate left by 61, substitute the top nibble, fold the round counter into bits 19:15
   always_comb begin
      rot_c               = {key_in[18:0], key_in[79:19]};
      key_next_c          = rot_c;
      key_next_c[79:76]   = sbox(rot_c[79:76]);
      key_next_c[19:15]   = rot_c[19:15] ^ round_cnt;
   end

endmodule

module present_key_scheduler #(
   parameter int unsigned NUM_RK = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid_i,
   input  logic [79:0] key_i,
   output logic        key_ready_o,
   input  logic        abort_i,
   output logic        rk_valid_o,
   input  logic        rk_ready_i,
   output logic [63:0] rk_o,
   output logic [5:0]  rk_idx_o,
   output logic        last_o,
   output logic        done_o,
   output logic        busy_o
);

   localparam int unsigned KEY_W = 80;
   localparam int unsigned RK_W  = 64;
   localparam int unsigned IDX_W = 6;
   localparam int unsigned RC_W  = 5;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK);

   // Catch an out-of-range round-key count at elaboration
   generate
      if (NUM_RK < 2 || NUM_RK > 32) begin : g_bad_num_rk
         $error("present_key_scheduler: NUM_RK must be in 2..32");
      end
   endgenerate

   logic [0:0]       state_q, state_d;
   logic [KEY_W-1:0] key_q,   key_d;
   logic [IDX_W-1:0] round_q, round_d;
   logic             done_q,  done_d;
   logic [KEY_W-1:0] key_upd_c;
   logic             in_run_c;
   logic             at_last_c;

   assign in_run_c  = (state_q == ST_RUN);
   assign at_last_c = (round_q == LAST_IDX);

   // Single shared key-update stage, fed by the low 5 bits of the round counter
   key_update u_key_update (
      .key_in     (key_q),
      .round_cnt  (round_q[RC_W-1:0]),
      .key_next_c (key_upd_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; abort overrides both handshakes
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      done_d  = 1'b0;
      if (abort_i) begin
         state_d = ST_IDLE;
         round_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (key_valid_i) begin
                  key_d   = key_i;
                  round_d = IDX_W'(1);
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (rk_ready_i) begin
                  if (at_last_c) begin
                     // Final key accepted: hold key_reg, pulse done next cycle
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     key_d   = key_upd_c;
                     round_d = round_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               round_d = '0;
            end
         endcase
      end
   end

   // Stream outputs are decodes of the registered state
   assign key_ready_o = (state_q == ST_IDLE) && !abort_i;
   assign rk_valid_o  = in_run_c;
   assign rk_o        = key_q[KEY_W-1 -: RK_W];
   assign rk_idx_o    = round_q;
   assign last_o      = in_run_c && at_last_c;
   assign done_o      = done_q;
   assign busy_o      = in_run_c;

endmodule
